// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply/divide unit: signed/unsigned MULT and DIV.
// One radix-2 step per cycle over a shared 64-bit accumulator, followed
// by a two-cycle sign-fix phase. Fixed 34-edge latency from start to done.
module muldiv_unit (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [4:0]  count_reg;
   logic [63:0] acc_reg;
   logic [31:0] b_mag_reg;
   logic        is_div_reg;
   logic        neg_q_reg;
   logic        neg_r_reg;
   logic        div_zero_reg;

   // Operand decode for the start cycle: magnitudes and result signs.
   logic        op_signed;
   logic [31:0] a_mag, b_mag;
   assign op_signed = ~op[0];
   assign a_mag = (op_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
   assign b_mag = (op_signed && src_b[31]) ? (32'd0 - src_b) : src_b;

   // Multiply step: conditional add of the multiplicand into the upper half,
   // then shift the whole accumulator right by one.
   logic [32:0] mul_sum;
   logic [63:0] mul_step;
   assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, b_mag_reg} : 33'd0);
   assign mul_step = {mul_sum, acc_reg[31:1]};

   // Divide step: upper half is the remainder, lower half shifts dividend
   // bits out and quotient bits in. A zero divisor naturally yields an
   // all-ones quotient and the dividend as remainder.
   logic [32:0] div_shift;
   logic [33:0] div_diff;
   logic [63:0] div_step;
   assign div_shift = {acc_reg[63:32], acc_reg[31]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, b_mag_reg};
   assign div_step  = div_diff[33] ? {div_shift[31:0], acc_reg[30:0], 1'b0}
                                   : {div_diff[31:0],  acc_reg[30:0], 1'b1};

   // Sign correction applied in the first FIX cycle. The quotient of a
   // divide by zero stays all-ones regardless of operand signs.
   logic [63:0] mul_fixed, div_fixed;
   assign mul_fixed = neg_q_reg ? (64'd0 - acc_reg) : acc_reg;
   assign div_fixed = {neg_r_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32],
                       (neg_q_reg && !div_zero_reg) ? (32'd0 - acc_reg[31:0]) : acc_reg[31:0]};

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic: CALC runs counter 0..31, FIX runs counter 0..1.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (count_reg == 5'd31) state_next = FIX;
         FIX:     if (count_reg == 5'd1) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath, counter and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg    <= 5'd0;
         acc_reg      <= 64'd0;
         b_mag_reg    <= 32'd0;
         is_div_reg   <= 1'b0;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
         div_zero_reg <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         hi           <= 32'd0;
         lo           <= 32'd0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  count_reg    <= 5'd0;
                  acc_reg      <= {32'd0, a_mag};
                  b_mag_reg    <= b_mag;
                  is_div_reg   <= op[1];
                  neg_q_reg    <= op_signed && (src_a[31] ^ src_b[31]);
                  neg_r_reg    <= op_signed && src_a[31];
                  div_zero_reg <= (src_b == 32'd0);
                  busy         <= 1'b1;
               end
            end
            CALC: begin
               acc_reg   <= is_div_reg ? div_step : mul_step;
               count_reg <= (count_reg == 5'd31) ? 5'd0 : count_reg + 5'd1;
            end
            FIX: begin
               if (count_reg == 5'd0) begin
                  acc_reg   <= is_div_reg ? div_fixed : mul_fixed;
                  count_reg <= 5'd1;
               end else begin
                  hi        <= acc_reg[63:32];
                  lo        <= acc_reg[31:0];
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  count_reg <= 5'd0;
               end
            end
            default: begin
               count_reg <= 5'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: arithmetic results, latency,
// divide-by-zero/overflow corners, ignored start, back-to-back, mid-op reset.
module tb_muldiv_unit;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   muldiv_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive a start request; returns #1 after the start edge.
   task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op    = o;
      src_a = a;
      src_b = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges after the start edge until done is seen (bounded).
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int lat;
      start_op(o, a, b);
      wait_done(lat);
      $display("op=%b a=%h b=%h -> hi=%h lo=%h latency=%0d (%s)", o, a, b, hi, lo, lat, tag);
      check({tag, "_latency"}, 64'(lat), 64'd34);
      check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
      check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
   endtask

   initial begin
      int lat;
      int done_seen;
      start   = 1'b0;
      op      = 2'b00;
      src_a   = 32'd0;
      src_b   = 32'd0;
      reset_n = 1'b0;
      #1;
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Accepted on the first rising edge after reset release.
      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      check("multu_max_busy_after", {63'd0, busy}, 64'd0);
      run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
      run_op("div_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

      // Start pulsed at cycle 10 of a busy op must be ignored.
      start_op(OP_MULTU, 32'h1234_5678, 32'h0000_0010);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (i == 10) begin
            check("ignore_busy", {63'd0, busy}, 64'd1);
            check("ignore_hold_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
            op    = OP_DIVU;
            src_a = 32'd1;
            src_b = 32'd1;
            start = 1'b1;
         end
         if (i == 11) start = 1'b0;
         if (done) begin
            lat = i;
            break;
         end
      end
      $display("op=%b ignored-start -> hi=%h lo=%h latency=%0d", OP_MULTU, hi, lo, lat);
      check("ignore_latency", 64'(lat), 64'd34);
      check("ignore_result", {hi, lo}, 64'h0000_0001_2345_6780);

      // Back-to-back: start issued in the done cycle.
      run_op("b2b_first", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("b2b_second", OP_MULT, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000);

      // Reset at CALC cycle 15 aborts the operation.
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (15) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      $display("reset mid-op -> busy=%b hi=%h lo=%h", busy, hi, lo);
      check("midreset_busy", {63'd0, busy}, 64'd0);
      check("midreset_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) done_seen++;
      end
      $display("after mid-op reset -> done pulses=%0d hi=%h lo=%h", done_seen, hi, lo);
      check("midreset_no_done", 64'(done_seen), 64'd0);
      check("midreset_hilo_after", {hi, lo}, 64'd0);

      run_op("post_reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-005 SHALL have port src_a, input, 32 bits: multiplicand or dividend, driven from register-file read port 0.
REQ-006 SHALL have port src_b, input, 32 bits: multiplier or divisor, driven from register-file read port 1.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo are updated.
REQ-009 SHALL have port hi, output, 32 bits: product upper word or remainder.
REQ-010 SHALL have port lo, output, 32 bits: product lower word or quotient.

Function
REQ-011 SHALL implement the states IDLE, CALC and FIX, and SHALL contain no other reachable state.
REQ-012 In IDLE with start=1, SHALL latch op, src_a and src_b on that edge, go to CALC, clear the 5-bit iteration counter, and set busy=1.
REQ-013 In IDLE with start=0, SHALL hold all registers.
REQ-014 SHALL ignore start while busy=1: no restart, and no change to latched operands.
REQ-015 For signed ops, SHALL latch operand magnitudes plus the result sign (MULT/DIV quotient: sign_a XOR sign_b; remainder: sign_a).
REQ-016 In CALC, SHALL perform exactly one radix-2 step per cycle for 32 cycles (counter 0..31), then go to FIX when counter=31.
REQ-017 Multiply SHALL use shift-add on a 64-bit accumulator; MULTU and MULT SHALL give exact 64-bit results, {hi,lo} = src_a*src_b.
REQ-018 Divide SHALL use restoring shift-subtract with a 33-bit partial remainder; DIVU SHALL give lo=floor(a/b) and hi=a mod b.
REQ-019 DIV SHALL truncate toward zero, and the remainder SHALL take the dividend's sign.
REQ-020 In FIX, SHALL apply two's-complement sign correction, write hi/lo, and go to IDLE.
REQ-021 On the edge leaving FIX, SHALL register done=1 for exactly one cycle and busy=0.
REQ-022 Latency SHALL be fixed: done=1 and the new hi/lo are visible in the cycle after the 34th rising edge following the start edge, for every op and operand value.
REQ-023 A start in the same cycle as done=1 SHALL be accepted, so back-to-back operations run with no idle gap.
REQ-024 Divide by zero SHALL complete with normal latency and SHALL give lo=32'hFFFF_FFFF and hi=src_a, for both DIV and DIVU.
REQ-025 Signed overflow DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL give lo=32'h8000_0000 and hi=0.
REQ-026 hi and lo SHALL hold their last result until the next FIX; they SHALL NOT change during CALC.
REQ-027 Outputs SHALL be driven only from registers, with no combinational path from any input to any output.

Reset
REQ-028 On reset_n=0, immediately and regardless of clk, SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and the accumulator to 0.
REQ-029 Reset asserted mid-operation (CALC or FIX) SHALL abort the operation, and SHALL produce no done pulse and no hi/lo update.
REQ-030 After reset_n rises, SHALL accept start on the first rising edge.

Verification
REQ-031 Bench SHALL check: MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001; done exactly 34 edges after the start edge.
REQ-032 Bench SHALL check: MULT a=-3 (32'hFFFF_FFFD), b=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-033 Bench SHALL check: DIV a=-7, b=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
REQ-034 Bench SHALL check: DIVU a=5, b=0 -> lo=32'hFFFF_FFFF, hi=5; DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
REQ-035 Bench SHALL check: start pulsed at cycle 10 of a busy op -> ignored, and the original result is unchanged; a new start in the done cycle -> second result 34 edges later.
REQ-036 Bench SHALL check: reset_n pulsed low at CALC cycle 15 -> busy=0, hi=lo=0 immediately, and no done pulse afterward.
